// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with a separate occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a build-time choice of registered or FWFT read data.
module sync_fifo_flags #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_LEVEL   = DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 2,
  parameter int unsigned FWFT       = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic [DATA_WIDTH-1:0]      wr_data_i,
  input  logic                       rd_en_i,
  output logic [DATA_WIDTH-1:0]      rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
  input  logic                       clr_err_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] AfLvl  = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AeLvl  = CW'(AE_LEVEL);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : gen_bad_af
    $error("sync_fifo_flags: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL > DEPTH - 1) begin : gen_bad_ae
    $error("sync_fifo_flags: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  wr_accept, rd_accept;

  assign full_o         = (count_q == DepthC);
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= AfLvl);
  assign almost_empty_o = (count_q <= AeLvl);
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  // A full FIFO can still take a write when the head word leaves in the same cycle.
  assign rd_accept = rd_en_i && !empty_o;
  assign wr_accept = wr_en_i && (!full_o || rd_accept);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_accept && !rd_accept) begin
      count_d = count_q + 1'b1;
    end else if (!wr_accept && rd_accept) begin
      count_d = count_q - 1'b1;
    end
    // A new error event takes priority over a clear in the same cycle.
    overflow_d  = clr_err_i ? 1'b0 : overflow_q;
    underflow_d = clr_err_i ? 1'b0 : underflow_q;
    if (wr_en_i && !wr_accept) overflow_d  = 1'b1;
    if (rd_en_i && empty_o)    underflow_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data_i;
  end

  if (FWFT == 0) begin : gen_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rd_data_q <= '0;
      end else if (rd_accept) begin
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
    assign rd_data_o = rd_data_q;
  end else begin : gen_fwft
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a standard-read and an FWFT instance share one stimulus.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] wr_data;

  logic [7:0] s_rd_data, f_rd_data;
  logic [3:0] s_count, f_count;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] exp_d;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(s_rd_data), .full_o(s_full), .empty_o(s_empty), .almost_full_o(s_af),
    .almost_empty_o(s_ae), .count_o(s_count), .overflow_o(s_ovf), .underflow_o(s_udf),
    .clr_err_i(clr_err)
  );

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(f_rd_data), .full_o(f_full), .empty_o(f_empty), .almost_full_o(f_af),
    .almost_empty_o(f_ae), .count_o(f_count), .overflow_o(f_ovf), .underflow_o(f_udf),
    .clr_err_i(clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, sample 1 ns after the edge, then idle the inputs.
  task automatic cyc(input logic we, input logic [7:0] wd, input logic re, input logic ce);
    wr_en = we; wr_data = wd; rd_en = re; clr_err = ce;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
    #3;
    chk("rst_count", 32'(s_count), 0);
    chk("rst_empty", 32'(s_empty), 1);
    chk("rst_ae", 32'(s_ae), 1);
    chk("rst_full", 32'(s_full), 0);
    chk("rst_af", 32'(s_af), 0);
    chk("rst_rd_data", 32'(s_rd_data), 0);
    chk("rst_ovf_udf", 32'({s_ovf, s_udf}), 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. fill / drain
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      chk("fill_count", 32'(s_count), 32'(i + 1));
      chk("fill_af", 32'(s_af), 32'((i + 1) >= 6));
      chk("fill_full", 32'(s_full), 32'((i + 1) == 8));
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_data", 32'(s_rd_data), 32'(8'h10 + i));
      chk("drain_ae", 32'(s_ae), 32'((7 - i) <= 2));
    end
    chk("drain_empty", 32'(s_empty), 1);

    // 2. overflow
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_flag", 32'(s_ovf), 1);
    chk("ovf_count", 32'(s_count), 8);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("ovf_drain", 32'(s_rd_data), 32'(8'h20 + i));
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(s_ovf), 0);

    // 3. underflow
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_flag", 32'(s_udf), 1);
    chk("udf_hold", 32'(s_rd_data), 32'h27);
    chk("udf_count", 32'(s_count), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("udf_set_wins", 32'(s_udf), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("udf_clr", 32'(s_udf), 0);

    // 4. simultaneous events
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("full_wr_rd_count", 32'(s_count), 8);
    chk("full_wr_rd_ovf", 32'(s_ovf), 0);
    chk("full_wr_rd_data", 32'(s_rd_data), 32'h30);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("full_wr_rd_drain", 32'(s_rd_data), (i == 7) ? 32'h55 : 32'(8'h31 + i));
    end
    cyc(1'b1, 8'h66, 1'b1, 1'b0);
    chk("empty_wr_rd_count", 32'(s_count), 1);
    chk("empty_wr_rd_udf", 32'(s_udf), 1);
    chk("empty_wr_rd_hold", 32'(s_rd_data), 32'h55);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("empty_wr_rd_word", 32'(s_rd_data), 32'h66);
    chk("empty_wr_rd_clr", 32'(s_udf), 0);

    // 5. wrap-around with count between 3 and 5
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      q.push_back(8'(8'h80 + i));
    end
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 2; k++) begin
        cyc(1'b1, 8'(8'h90 + 2 * i + k), 1'b0, 1'b0);
        q.push_back(8'(8'h90 + 2 * i + k));
        chk("wrap_wr_count", 32'(s_count), 32'(q.size()));
      end
      for (int k = 0; k < 2; k++) begin
        exp_d = q.pop_front();
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_rd_data", 32'(s_rd_data), 32'(exp_d));
        chk("wrap_rd_count", 32'(s_count), 32'(q.size()));
      end
    end
    chk("wrap_flags", 32'({s_ovf, s_udf, s_full, s_empty}), 0);

    // 6. FWFT and reset mid-operation
    rst_n = 1'b0; #2; rst_n = 1'b1;
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("fwft_first", 32'(f_rd_data), 32'h3C);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fwft_hold", 32'(f_rd_data), 32'h3C);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h3D + i), 1'b0, 1'b0);
    chk("fwft_head", 32'(f_rd_data), 32'h3C);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_pop", 32'(f_rd_data), 32'h3D);
    chk("fwft_pop_count", 32'(f_count), 3);
    cyc(1'b1, 8'h40, 1'b0, 1'b0);
    chk("fwft_count4", 32'(f_count), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("fwft_rst_count", 32'(f_count), 0);
    chk("fwft_rst_empty", 32'(f_empty), 1);
    chk("fwft_rst_data", 32'(f_rd_data), 0);
    rst_n = 1'b1;
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    chk("fwft_after_rst", 32'(f_rd_data), 32'h77);
    chk("fwft_after_rst_count", 32'(f_count), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_empty_data", 32'(f_rd_data), 0);
    chk("fwft_empty_flag", 32'(f_empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parametrised single-clock FIFO; next generation of the team's synchronous FIFO.
- Adds four features:
  - programmable almost-full and almost-empty thresholds;
  - an occupancy count;
  - sticky overflow and underflow error flags;
  - a compile-time choice between standard read mode and first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer stages that need early back-pressure warning.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- DEPTH, 8, number of entries. Must be a power of two, ≥2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL. Legal range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL. Legal range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (in FWFT mode: pop/acknowledge of the head word).
- rd_data  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH)+1  number of words stored.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was rejected.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset:
  - Asynchronous on rst_n low; takes effect immediately.
  - All of the following go to 0: wr_ptr, rd_ptr, count, rd_data, overflow, underflow, full, almost_full.
  - empty=1 and almost_empty=1.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words. The first write after rst_n deasserts is stored at address 0.
- Pointers:
  - Width is $clog2(DEPTH).
  - Natural wrap from DEPTH-1 to 0.
  - count is a separate register, which avoids full/empty ambiguity.
- Write accept:
  - wr_accept = wr_en && (!full || rd_accept).
  - On accept: mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read accept:
  - rd_accept = rd_en && !empty.
  - On accept, rd_ptr increments.
  - A read on empty is never accepted, even if a write occurs in the same cycle.
- count update:
  - +1 on write only, -1 on read only.
  - Unchanged when both or neither are accepted.
- Flags:
  - full, empty, almost_full and almost_empty are combinational functions of the registered count.
  - They update the cycle after the causing edge.
- Standard mode (FWFT=0):
  - On rd_accept, rd_data <= mem[rd_ptr] at the same edge. The data is valid from the cycle after rd_en, i.e. 1-cycle read latency.
  - rd_data holds its value when no read is accepted.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] whenever !empty.
  - rd_en acknowledges the current word; the next word is presented in the following cycle.
  - rd_data is 0 while empty.
  - A word written into an empty FIFO appears on rd_data the cycle after the write edge.
- Full + write + read in the same cycle: both accepted; count stays DEPTH; no overflow.
- Empty + write + read in the same cycle: write accepted, read rejected; underflow sets; count becomes 1.
- Overflow: wr_en while full and no rd_accept → write dropped, memory and pointers unchanged, overflow <= 1.
- Underflow: rd_en while empty → pointers unchanged, rd_data holds, underflow <= 1.
- Error clear: clr_err clears both sticky flags at the next edge. If a new error event occurs in the same cycle as clr_err, set wins.
- Parameter checks: illegal parameter values (DEPTH not a power of two, AF_LEVEL or AE_LEVEL out of range) are rejected by an elaboration-time assertion.

Test Plan:
All scenarios use DEPTH=8, DATA_WIDTH=8, AF_LEVEL=6, AE_LEVEL=2.
1. Fill/drain, FWFT=0: write 0x10..0x17 → full=1 and count=8 after the 8th edge; almost_full rises at count=6. Then 8 reads → rd_data=0x10..0x17 in order, each one cycle after its rd_en; empty=1 at the end; almost_empty rises at count=2.
2. Overflow: with the FIFO full, write 0xAA → overflow=1, count=8, the subsequent drain shows no 0xAA. Pulse clr_err → overflow=0.
3. Underflow: on an empty FIFO assert rd_en → underflow=1, rd_data unchanged, count=0. Then clr_err and rd_en on empty in the same cycle → underflow stays 1.
4. Simultaneous events:
   - When full, write 0x55 and read together → count stays 8, no overflow, 0x55 emerges last.
   - When empty, write and read together → count=1, underflow=1.
5. Wrap-around: 20 interleaved write/read pairs with count oscillating between 3 and 5 → data order preserved across the pointer wrap; no flags set.
6. FWFT=1 and reset mid-operation:
   - Write 0x3C into an empty FIFO → rd_data=0x3C the next cycle with no rd_en.
   - With 4 words stored, pulse rst_n low between edges → count=0, empty=1 and rd_data=0 immediately.
   - First write after reset (0x77) appears on rd_data the next cycle.
